sync_shake_arb: RTL

SYNC_SHAKE_ARB -- requirements
Module: sync_shake_arb

---
 rtl/sync_shake_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sync_shake_arb.sv
// sync_shake_arb
//   Round-robin arbiter that collects one beat at a time from N requesters and
//   presents it to a single valid/ack channel. The channel feeds a cross-clock
//   handshake, so a beat may stall for a long time. A stall timeout raises a
//   sticky error flag but never drops the beat.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req_vld      [N]    per-requester valid
//   req_data     [N*W]  requester i data in bits [i*W +: W]
//   req_ack      [N]    combinational accept, one-hot or zero, IDLE only
//   en_mask      [N]    requester enable; masked requesters are never granted
//   tx_vld       channel valid, high exactly while in SEND
//   tx_data      [W]    held beat data
//   tx_id        [IDW]  index of the requester that owns the held beat
//   tx_ack       channel accept
//   busy         high while in SEND
//   err_timeout  sticky stall-timeout flag
//   err_clr      clears err_timeout; a coincident set wins
//   beat_cnt     [16]   transferred beat count, wraps
module sync_shake_arb #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255,
  localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_vld,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ack,
  input  logic [N-1:0]     en_mask,
  output logic             tx_vld,
  output logic [W-1:0]     tx_data,
  output logic [IDW-1:0]   tx_id,
  input  logic             tx_ack,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [15:0]      beat_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic [15:0]      beat_q, beat_d;

  logic [N-1:0]     cand;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic             err_set;

  // Scan ptr+1, ptr+2, ... modulo N and return {found, index} of the first
  // candidate. Starting one past the last winner gives round-robin order.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] c,
                                           input logic [IDW-1:0] p);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(p) + k) % N;
      if (!found && ((c >> j) & N'(1)) != '0) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    beat_d  = beat_q;
    req_ack = '0;
    err_set = 1'b0;

    cand               = req_vld & en_mask;
    {gnt_vld, gnt_idx} = rr_pick(cand, ptr_q);

    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ack = N'(1) << gnt_idx;
          hold_d  = W'(req_data >> (gnt_idx * W));
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          tcnt_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ack) begin
          state_d = S_IDLE;
          beat_d  = beat_q + 16'd1;
        end else if (tcnt_q != TO_LIM) begin
          tcnt_d = tcnt_q + 16'd1;
          // Flag only on the step that reaches the limit, so a clear during a
          // long saturated stall is not immediately overridden.
          err_set = (tcnt_d == TO_LIM);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(N - 1);
      id_q    <= '0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
    end
  end

  assign tx_vld      = (state_q == S_SEND);
  assign busy        = (state_q == S_SEND);
  assign tx_data     = hold_q;
  assign tx_id       = id_q;
  assign err_timeout = err_q;
  assign beat_cnt    = beat_q;

endmodule
